// File: rtl/control_pipe_hazard.sv
// ---------------------------------------------------------------------------
// control_pipe_hazard
//   Control-pipeline owner for the 5-stage RV32I core. Takes the decode-stage
//   control bundle, carries it through the E, M and W pipeline registers,
//   resolves branches/jumps in E, detects load-use hazards and drives the
//   stall, flush and forwarding selects for the datapath.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   *D inputs           decode-stage control bundle and register addresses
//   zeroE, ltE          ALU flags for the instruction currently in E
//   ALUControlE, ALUSrcE, luiE   registered E-stage ALU controls
//   PCSrcE              00 PC+4, 01 PC+imm, 10 ALU result (jalr)
//   forwardAE/BE        00 regfile, 01 W result, 10 M ALU result
//   memWriteM           M-stage store enable
//   resultSrcW, regWriteW, rdW   W-stage writeback controls
//   stallF, stallD, flushD       front-end hazard controls
// ---------------------------------------------------------------------------
module control_pipe_hazard #(
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regWriteD,
    input  logic [1:0]      resultSrcD,
    input  logic            memWriteD,
    input  logic [1:0]      jumpD,
    input  logic [2:0]      branchD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            luiD,
    input  logic [RA_W-1:0] rs1D,
    input  logic [RA_W-1:0] rs2D,
    input  logic [RA_W-1:0] rdD,
    input  logic            zeroE,
    input  logic            ltE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            luiE,
    output logic [1:0]      PCSrcE,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            memWriteM,
    output logic [1:0]      resultSrcW,
    output logic            regWriteW,
    output logic [RA_W-1:0] rdW,
    output logic            stallF,
    output logic            stallD,
    output logic            flushD
);

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_JAL  = 2'b01,
        JUMP_JALR = 2'b10
    } jump_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100
    } branch_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } res_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic            regWrite;
        logic [1:0]      resultSrc;
        logic            memWrite;
        logic [1:0]      jump;
        logic [2:0]      branch;
        logic [2:0]      aluCtrl;
        logic            aluSrc;
        logic            lui;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } ctrl_e_t;

    ctrl_e_t         e_q, e_d;

    logic            regWriteM_q;
    logic [1:0]      resultSrcM_q;
    logic            memWriteM_q;
    logic [RA_W-1:0] rdM_q;

    logic            regWriteW_q;
    logic [1:0]      resultSrcW_q;
    logic [RA_W-1:0] rdW_q;

    logic            takenE;
    logic            redirect;
    logic            lwStall;
    logic            flushE;

    // Branch resolution; undefined branch codes fall into default (not taken).
    always_comb begin
        takenE = 1'b0;
        case (e_q.branch)
            BR_BEQ:  takenE = zeroE;
            BR_BNE:  takenE = ~zeroE;
            BR_BLT:  takenE = ltE;
            BR_BGE:  takenE = ~ltE;
            default: takenE = 1'b0;
        endcase
    end

    always_comb begin
        PCSrcE = 2'b00;
        if (e_q.jump == JUMP_JALR)
            PCSrcE = 2'b10;
        else if ((e_q.jump == JUMP_JAL) || takenE)
            PCSrcE = 2'b01;
    end

    assign redirect = (PCSrcE != 2'b00);

    assign lwStall = (e_q.resultSrc == RES_LOAD) && (e_q.rd != '0) &&
                     ((e_q.rd == rs1D) || (e_q.rd == rs2D));

    // A redirect squashes the stalled instruction anyway, so it wins over the stall.
    assign stallF = lwStall & ~redirect;
    assign stallD = lwStall & ~redirect;
    assign flushD = redirect;
    assign flushE = lwStall | redirect;

    always_comb begin
        e_d.regWrite  = regWriteD;
        e_d.resultSrc = resultSrcD;
        e_d.memWrite  = memWriteD;
        e_d.jump      = jumpD;
        e_d.branch    = branchD;
        e_d.aluCtrl   = ALUControlD;
        e_d.aluSrc    = ALUSrcD;
        e_d.lui       = luiD;
        e_d.rs1       = rs1D;
        e_d.rs2       = rs2D;
        e_d.rd        = rdD;
        if (flushE)
            e_d = '0;
    end

    // Forwarding: M has priority over W; x0 never forwards.
    always_comb begin
        forwardAE = FWD_RF;
        if (regWriteM_q && (rdM_q != '0) && (rdM_q == e_q.rs1))
            forwardAE = FWD_M;
        else if (regWriteW_q && (rdW_q != '0) && (rdW_q == e_q.rs1))
            forwardAE = FWD_W;
    end

    always_comb begin
        forwardBE = FWD_RF;
        if (regWriteM_q && (rdM_q != '0) && (rdM_q == e_q.rs2))
            forwardBE = FWD_M;
        else if (regWriteW_q && (rdW_q != '0) && (rdW_q == e_q.rs2))
            forwardBE = FWD_W;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q          <= '0;
            regWriteM_q  <= 1'b0;
            resultSrcM_q <= '0;
            memWriteM_q  <= 1'b0;
            rdM_q        <= '0;
            regWriteW_q  <= 1'b0;
            resultSrcW_q <= '0;
            rdW_q        <= '0;
        end else begin
            e_q          <= e_d;
            regWriteM_q  <= e_q.regWrite;
            resultSrcM_q <= e_q.resultSrc;
            memWriteM_q  <= e_q.memWrite;
            rdM_q        <= e_q.rd;
            regWriteW_q  <= regWriteM_q;
            resultSrcW_q <= resultSrcM_q;
            rdW_q        <= rdM_q;
        end
    end

    assign ALUControlE = e_q.aluCtrl;
    assign ALUSrcE     = e_q.aluSrc;
    assign luiE        = e_q.lui;
    assign memWriteM   = memWriteM_q;
    assign resultSrcW  = resultSrcW_q;
    assign regWriteW   = regWriteW_q;
    assign rdW         = rdW_q;

endmodule
